// File: rtl/grid_plotter_pkg.sv
// Shared grid geometry, colours and plotter state encoding.
// Used by grid_plotter and the grid writer.
package grid_pkg;

  localparam int GRID_W   = 160;
  localparam int GRID_H   = 120;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int CELLS    = GRID_W * GRID_H;
  localparam int IDX_W    = $clog2(CELLS);

  localparam logic [COLOUR_W-1:0] FG_COLOUR = 3'b111;
  localparam logic [COLOUR_W-1:0] BG_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

  // Flat occupancy bit for cell (cx, cy); columns are GRID_H bits apart.
  function automatic logic [IDX_W-1:0] cell_index(input logic [X_W-1:0] cx,
                                                  input logic [Y_W-1:0] cy);
    return IDX_W'(cx) * IDX_W'(GRID_H) + IDX_W'(cy);
  endfunction

endpackage

// File: rtl/grid_plotter_if.sv
// Plotter bus: control, live grid input and the VGA pixel-write handshake.
interface grid_plotter_if;
  import grid_pkg::*;

  logic                start;
  logic [CELLS-1:0]    grid;
  logic                plot_ready;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    input  start, grid, plot_ready,
    output x, y, colour, plot, busy, done
  );

  modport slave (
    output start, grid, plot_ready,
    input  x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/grid_plotter_cell_counter.sv
// Column-major cell counter: cy runs fastest, cx advances when cy wraps.
module grid_cell_counter
  import grid_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic           enable,
  output logic [X_W-1:0] cx,
  output logic [Y_W-1:0] cy,
  output logic           last
);

  logic [X_W-1:0] cx_reg, cx_next;
  logic [Y_W-1:0] cy_reg, cy_next;
  logic           col_end;
  logic           row_end;

  assign col_end = (cy_reg == Y_W'(GRID_H - 1));
  assign row_end = (cx_reg == X_W'(GRID_W - 1));

  always_comb begin
    cx_next = cx_reg;
    cy_next = cy_reg;
    if (clear) begin
      cx_next = '0;
      cy_next = '0;
    end else if (enable) begin
      if (col_end) begin
        cy_next = '0;
        // Wrap after the final cell so cx never reaches GRID_W.
        cx_next = row_end ? '0 : cx_reg + 1'b1;
      end else begin
        cy_next = cy_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cx_reg <= '0;
      cy_reg <= '0;
    end else begin
      cx_reg <= cx_next;
      cy_reg <= cy_next;
    end
  end

  assign cx   = cx_reg;
  assign cy   = cy_reg;
  assign last = col_end && row_end;

endmodule

// File: rtl/grid_plotter.sv
// Walks the bullet grid column-major, one VGA pixel write per cell.
// Define GRID_PLOTTER_ERASE_EN to also emit background pixels for empty cells.
module grid_plotter
  import grid_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  grid_plotter_if.master bus
);

`ifdef GRID_PLOTTER_ERASE_EN
  localparam logic ERASE_EN = 1'b1;
`else
  localparam logic ERASE_EN = 1'b0;
`endif

  state_t              state_reg, state_next;
  logic [X_W-1:0]      x_reg, x_next;
  logic [Y_W-1:0]      y_reg, y_next;
  logic [COLOUR_W-1:0] colour_reg, colour_next;
  logic                plot_reg, plot_next;
  logic                done_reg, done_next;

  logic                cnt_clear;
  logic                cnt_enable;
  logic [X_W-1:0]      cx;
  logic [Y_W-1:0]      cy;
  logic                last_cell;
  logic                slot_free;
  logic                cell_bit;

  grid_cell_counter u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .cx     (cx),
    .cy     (cy),
    .last   (last_cell)
  );

  // The grid is read live; the bit is captured only when the cell is loaded.
  assign cell_bit  = bus.grid[cell_index(cx, cy)];
  assign slot_free = !plot_reg || bus.plot_ready;

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    colour_next = colour_reg;
    plot_next   = plot_reg;
    done_next   = 1'b0;
    cnt_clear   = 1'b0;
    cnt_enable  = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_clear = 1'b1;
        if (bus.start) state_next = SCAN;
      end
      SCAN: begin
        if (slot_free) begin
          cnt_enable  = 1'b1;
          x_next      = cx;
          y_next      = cy;
          colour_next = cell_bit ? FG_COLOUR : BG_COLOUR;
          plot_next   = ERASE_EN | cell_bit;
          if (last_cell) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (slot_free) begin
          plot_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      colour_reg <= BG_COLOUR;
      plot_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      colour_reg <= colour_next;
      plot_reg   <= plot_next;
      done_reg   <= done_next;
    end
  end

  assign bus.x      = x_reg;
  assign bus.y      = y_reg;
  assign bus.colour = colour_reg;
  assign bus.plot   = plot_reg;
  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = done_reg;

endmodule
